// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmit arbiter.
//   arb_state_e  : arbiter FSM states (ARB_IDLE, ARB_WAIT)
//   DBIT_DEFAULT : default data byte width
//   clog2()      : index width helper, never returns less than 1
package uart_pkg;

  localparam int unsigned DBIT_DEFAULT = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick -- combinational round-robin priority picker.
//   req_i    [NREQ] : request vector
//   ptr_i    [PW]   : index of the last winner; search starts at ptr_i+1
//   winner_o [PW]   : first set request at or after ptr_i+1, wrapping mod NREQ
//   any_o           : at least one request is set
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [PW-1:0]   winner_o,
  output logic            any_o
);

  // Offsets 1..NREQ from the pointer are scanned in order; the first hit wins.
  // Offset NREQ lands back on the pointer itself, so a lone requester can win again.
  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!any_o && req_i[j] && (j == (32'(ptr_i) + k) % NREQ)) begin
          any_o    = 1'b1;
          winner_o = PW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb -- round-robin arbiter sharing one UART transmitter between
// NREQ byte producers. The winner's byte is latched and a one-cycle tx_start is
// issued; ownership is held until the transmitter's tx_done_tick.
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   req  [NREQ]   : level requests, held until ack
//   req_data      : flattened bytes, requester i at [i*DBIT +: DBIT]
//   ack  [NREQ]   : one-cycle pulse, byte accepted
//   done [NREQ]   : one-cycle pulse, byte fully transmitted
//   busy          : high from acceptance until done
//   owner         : current/last granted requester
//   tx_start      : one-cycle start strobe to the transmitter
//   tx_din        : byte to the transmitter, held until next grant
//   tx_done_tick  : transmitter completion pulse
//   err           : (UART_ARB_TIMEOUT_EN only) one-cycle watchdog abort pulse
// Optional feature macro: UART_ARB_TIMEOUT_EN adds a WAIT-state watchdog of
// TIMEOUT cycles; without it WAIT waits indefinitely for tx_done_tick.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter  int unsigned NREQ    = 4,
  parameter  int unsigned DBIT    = DBIT_DEFAULT,
  parameter  int unsigned TIMEOUT = 65535,
  localparam int unsigned PW      = clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DBIT-1:0] req_data,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [PW-1:0]        owner,
  output logic                 tx_start,
  output logic [DBIT-1:0]      tx_din,
  input  logic                 tx_done_tick
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                 err
`endif
);

  // Elaboration-time parameter guards.
  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("uart_tx_arb: NREQ must be in 2..16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("uart_tx_arb: TIMEOUT must be at least 1");
  end

  arb_state_e      state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   owner_q;
  logic [NREQ-1:0] ack_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q;
  logic            tx_start_q;
  logic [DBIT-1:0] tx_din_q;

  logic [PW-1:0]   pick_win;
  logic            pick_any;
  logic [DBIT-1:0] pick_byte;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CW = clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
`endif

  uart_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (pick_win),
    .any_o    (pick_any)
  );

  always_comb begin
    pick_byte = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_win == PW'(i)) pick_byte = req_data[i*DBIT +: DBIT];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= PW'(NREQ - 1);
      owner_q    <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_din_q   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      ack_q      <= '0;
      done_q     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
      case (state_q)
        ARB_IDLE: begin
          // tx_done_tick is deliberately ignored here.
          if (pick_any) begin
            tx_start_q      <= 1'b1;
            tx_din_q        <= pick_byte;
            ack_q[pick_win] <= 1'b1;
            owner_q         <= pick_win;
            ptr_q           <= pick_win;
            busy_q          <= 1'b1;
            state_q         <= ARB_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q           <= '0;
`endif
          end
        end
        ARB_WAIT: begin
          if (tx_done_tick) begin
            done_q[owner_q] <= 1'b1;
            busy_q          <= 1'b0;
            state_q         <= ARB_IDLE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          // Abort fires on the edge the counter would reach TIMEOUT, so err is
          // seen TIMEOUT cycles after tx_start; a same-cycle done tick wins above.
          else if (cnt_q >= CW'(TIMEOUT - 1)) begin
            err_q           <= 1'b1;
            done_q[owner_q] <= 1'b1;
            busy_q          <= 1'b0;
            state_q         <= ARB_IDLE;
          end else if (cnt_q != CW'(TIMEOUT)) begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign ack      = ack_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign owner    = owner_q;
  assign tx_start = tx_start_q;
  assign tx_din   = tx_din_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign err      = err_q;
`endif

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter sharing one UART transmitter (tx_start/din/tx_done_tick handshake) between NREQ byte producers, e.g. debug console, status reporter and command echo.
- Latches the winning requester's byte, issues a one-cycle tx_start to the transmitter and holds ownership until the transmitter's done tick.
- Returns per-requester accept and completion pulses.

Parameters:
NREQ, 4, number of requesters (2..16)
DBIT, 8, data byte width; must match the transmitter's data width
TIMEOUT, 65535, watchdog limit in clk cycles for the WAIT state (used only with UART_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NREQ  level request per requester; held until its ack pulse
req_data  in  NREQ*DBIT  flattened bytes; requester i uses bits [i*DBIT +: DBIT]; stable while req[i]=1
ack  out  NREQ  one-hot, one-cycle pulse: requester's byte accepted; it may drop req or present the next byte
done  out  NREQ  one-hot, one-cycle pulse: requester's byte fully transmitted (stop bit finished)
busy  out  1  high from acceptance until done
owner  out  $clog2(NREQ)  index of the current/last granted requester
tx_start  out  1  one-cycle start strobe to the transmitter
tx_din  out  DBIT  byte to the transmitter; valid with tx_start, held until next grant
tx_done_tick  in  1  transmitter completion pulse

Behaviour:
- All outputs registered. Reset values: ack=0, done=0, busy=0, owner=0, tx_start=0, tx_din=0, state=IDLE, rr pointer=NREQ-1 (requester 0 has first priority after reset).
- FSM states: IDLE, WAIT.
- IDLE, req==0: stay; outputs idle.
- IDLE, req!=0: the winner is the first set bit searching upward from ptr+1, wrapping modulo NREQ.
  - Next edge: tx_start=1, tx_din=req_data[winner], ack[winner]=1, owner=winner, busy=1, ptr=winner, state->WAIT.
  - Latency: req sampled high -> tx_start/ack on the following cycle (1 cycle).
- WAIT: tx_start, ack return to 0 after one cycle. req changes are ignored; no new grant.
- WAIT, tx_done_tick=1: next edge done[owner]=1, busy=0, state->IDLE. Earliest next grant is the cycle after that, so tx_start never coincides with the transmitter leaving its stop state.
- tx_done_tick while in IDLE: ignored, no done pulse.
- Simultaneous requests: exactly one grant; the others wait. Each requester is served at most once per NREQ grants while others request (fairness).
- Single requester holding req continuously: granted back-to-back; tx_start pulses separated by a full frame + 2 cycles.
- Requester dropping req before ack: simply not considered at the next arbitration; no ack issued.
- rst_n asserted mid-operation: immediate return to reset values. The transmitter is reset on the same net; no done pulse for the aborted byte.
- Width rule: owner and ptr are $clog2(NREQ) bits; wrap computed modulo NREQ (non-power-of-2 NREQ legal).

Optional Feature:
- Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - Adds output err (1 bit, reset 0) and a counter cleared on entry to WAIT.
  - If the counter reaches TIMEOUT without tx_done_tick: next edge err=1 for one cycle, done[owner]=1, busy=0, state->IDLE.
  - Counter saturates, never wraps.
  - tx_done_tick on the same cycle the counter hits TIMEOUT: normal completion, err stays 0.
- Undefined: no err port, no counter; WAIT waits indefinitely.

Decomposition:
- Shared package uart_pkg: state localparams (ARB_IDLE, ARB_WAIT), default DBIT, and a clog2 helper function.
- One sub-module, uart_rr_pick: combinational round-robin priority picker (inputs req, ptr; outputs winner index and any_req), reusable by a future RX dispatch block.

Test Plan:
- Reset: rst_n low then high, all req=0 -> all outputs 0 for 20 cycles; no tx_start.
- Single request: req=4'b0100, data2=8'hA5 -> one cycle later tx_start=1, tx_din=8'hA5, ack=4'b0100, owner=2. Drive tx_done_tick 200 cycles later -> done=4'b0100 next cycle, busy=0.
- Contention: req=4'b1111 held continuously, each requester re-presents data on ack -> grant order 0,1,2,3,0,1 with exactly one ack per tx_start.
- Reset mid-WAIT: after grant to requester 1, pulse rst_n low -> busy=0, ack=0, done=0 immediately; after release, req=4'b0011 -> requester 0 granted first.
- Spurious tx_done_tick in IDLE, and req toggling while in WAIT -> no done pulse, no extra tx_start until the real tx_done_tick.
- With UART_ARB_TIMEOUT_EN, TIMEOUT=100: grant, never return tx_done_tick -> at cycle 100 after grant err=1, done[owner]=1, then normal arbitration resumes.
